// File: rtl/pc_sequencer.sv
// Fetch-address sequencer: picks the next PC from sequential advance, stall hold,
// branch redirect or halt, and squashes IF/ID on every redirect.
module pc_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] pc,
  output logic [63:0] next_pc,
  input  logic        stall,
  input  logic        br_taken,
  input  logic [63:0] br_target,
  input  logic        halt,
  output logic        flush,
  output logic [1:0]  state,
  output logic        misalign,
  output logic [31:0] fetch_cnt
);

  localparam logic [1:0] S_RUN    = 2'b00;
  localparam logic [1:0] S_STALL  = 2'b01;
  localparam logic [1:0] S_FLUSH  = 2'b10;
  localparam logic [1:0] S_HALTED = 2'b11;

  localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

  logic [1:0]  r_state;
  logic [1:0]  w_state_nxt;
  logic        r_misalign;
  logic [31:0] r_fetch_cnt;
  logic [63:0] w_pc_inc;
  logic [63:0] w_br_aligned;
  logic        w_advance;
  logic        w_redirect;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == CNT_MAX) ? v : v + 32'd1;
  endfunction

  // pc+4 wraps naturally in 64 bits; branch targets are forced word-aligned.
  assign w_pc_inc     = pc + 64'd4;
  assign w_br_aligned = {br_target[63:2], 2'b00};

  // State register
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_RUN;
    else       r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_RUN, S_STALL: begin
        if (halt)          w_state_nxt = S_HALTED;
        else if (br_taken) w_state_nxt = S_FLUSH;
        else if (stall)    w_state_nxt = S_STALL;
        else               w_state_nxt = S_RUN;
      end
      S_FLUSH:  w_state_nxt = halt ? S_HALTED : S_RUN;
      default:  w_state_nxt = S_HALTED;
    endcase
  end

  // Mealy outputs; branch input is ignored in FLUSH since it belongs to a squashed instruction.
  always_comb begin
    next_pc    = pc;
    flush      = 1'b0;
    w_advance  = 1'b0;
    w_redirect = 1'b0;
    if (reset) begin
      next_pc = 64'h0;
      flush   = 1'b1;
    end else begin
      case (r_state)
        S_RUN, S_STALL: begin
          if (halt) begin
            next_pc = pc;
          end else if (br_taken) begin
            next_pc    = w_br_aligned;
            flush      = 1'b1;
            w_redirect = 1'b1;
          end else if (!stall) begin
            next_pc   = w_pc_inc;
            w_advance = 1'b1;
          end
        end
        S_FLUSH: begin
          flush = 1'b1;
          if (!halt) begin
            next_pc   = w_pc_inc;
            w_advance = 1'b1;
          end
        end
        default: begin
          next_pc = pc;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_misalign  <= 1'b0;
      r_fetch_cnt <= 32'd0;
    end else begin
      if (w_redirect && (br_target[1:0] != 2'b00)) r_misalign <= 1'b1;
      if (w_advance) r_fetch_cnt <= sat_inc(r_fetch_cnt);
    end
  end

  assign state     = r_state;
  assign misalign  = r_misalign;
  assign fetch_cnt = r_fetch_cnt;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios plus randomized traffic
// compared against a flag-based behavioural model.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] pc;
  logic [63:0] next_pc;
  logic        stall;
  logic        br_taken;
  logic [63:0] br_target;
  logic        halt;
  logic        flush;
  logic [1:0]  state;
  logic        misalign;
  logic [31:0] fetch_cnt;

  int checks = 0;
  int errors = 0;

  pc_sequencer dut (
    .clk       (clk),
    .reset     (reset),
    .pc        (pc),
    .next_pc   (next_pc),
    .stall     (stall),
    .br_taken  (br_taken),
    .br_target (br_target),
    .halt      (halt),
    .flush     (flush),
    .state     (state),
    .misalign  (misalign),
    .fetch_cnt (fetch_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    stall = 0; br_taken = 0; halt = 0; br_target = 64'h0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1; pc = 64'h0;
    tick();
    reset = 0;
  endtask

  task automatic test_reset();
    reset = 1; pc = 64'h1234; stall = 1; br_taken = 1; halt = 1; br_target = 64'h55;
    #1;
    checks++; if (next_pc !== 64'h0) begin errors++; $display("FAIL rst_npc: got %h want 0", next_pc); end
    checks++; if (flush !== 1'b1) begin errors++; $display("FAIL rst_flush: got %b want 1", flush); end
    tick();
    checks++; if (state !== 2'b00) begin errors++; $display("FAIL rst_state: got %b want 00", state); end
    checks++; if (misalign !== 1'b0) begin errors++; $display("FAIL rst_mis: got %b want 0", misalign); end
    checks++; if (fetch_cnt !== 32'd0) begin errors++; $display("FAIL rst_cnt: got %0d want 0", fetch_cnt); end
    reset = 0; idle_inputs();
  endtask

  task automatic test_sequential();
    logic [63:0] want;
    do_reset();
    pc = 64'h0;
    for (int i = 1; i <= 3; i++) begin
      want = 64'(4 * i);
      #1;
      checks++; if (next_pc !== want) begin errors++; $display("FAIL seq_npc%0d: got %h want %h", i, next_pc, want); end
      checks++; if (flush !== 1'b0) begin errors++; $display("FAIL seq_flush%0d: got %b want 0", i, flush); end
      tick();
      pc = want;
    end
    checks++; if (fetch_cnt !== 32'd3) begin errors++; $display("FAIL seq_cnt: got %0d want 3", fetch_cnt); end
    checks++; if (state !== 2'b00) begin errors++; $display("FAIL seq_state: got %b want 00", state); end
  endtask

  task automatic test_stall();
    do_reset();
    pc = 64'h10; stall = 1;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++; if (next_pc !== 64'h10) begin errors++; $display("FAIL stall_npc%0d: got %h want 10", i, next_pc); end
      tick();
      checks++; if (state !== 2'b01) begin errors++; $display("FAIL stall_state%0d: got %b want 01", i, state); end
    end
    stall = 0;
    #1;
    checks++; if (next_pc !== 64'h14) begin errors++; $display("FAIL stall_rel_npc: got %h want 14", next_pc); end
    tick();
    checks++; if (state !== 2'b00) begin errors++; $display("FAIL stall_rel_state: got %b want 00", state); end
    checks++; if (fetch_cnt !== 32'd1) begin errors++; $display("FAIL stall_cnt: got %0d want 1", fetch_cnt); end
    // Reset while stalled leaves no residue.
    stall = 1; tick();
    reset = 1; tick(); reset = 0; stall = 0; pc = 64'h0;
    checks++; if (state !== 2'b00) begin errors++; $display("FAIL stall_rst_state: got %b want 00", state); end
    #1;
    checks++; if (next_pc !== 64'h4) begin errors++; $display("FAIL stall_rst_npc: got %h want 4", next_pc); end
  endtask

  task automatic test_branch();
    do_reset();
    pc = 64'h20; br_taken = 1; br_target = 64'h100;
    #1;
    checks++; if (next_pc !== 64'h100) begin errors++; $display("FAIL br_npc: got %h want 100", next_pc); end
    checks++; if (flush !== 1'b1) begin errors++; $display("FAIL br_flush: got %b want 1", flush); end
    tick();
    checks++; if (state !== 2'b10) begin errors++; $display("FAIL br_state: got %b want 10", state); end
    // Branch and stall during FLUSH are ignored.
    pc = 64'h100; br_taken = 1; br_target = 64'h999; stall = 1;
    #1;
    checks++; if (next_pc !== 64'h104) begin errors++; $display("FAIL fl_npc: got %h want 104", next_pc); end
    checks++; if (flush !== 1'b1) begin errors++; $display("FAIL fl_flush: got %b want 1", flush); end
    tick();
    idle_inputs(); pc = 64'h104;
    checks++; if (state !== 2'b00) begin errors++; $display("FAIL fl_state: got %b want 00", state); end
    checks++; if (misalign !== 1'b0) begin errors++; $display("FAIL fl_mis: got %b want 0", misalign); end
    #1;
    checks++; if (flush !== 1'b0) begin errors++; $display("FAIL fl_after_flush: got %b want 0", flush); end
    checks++; if (fetch_cnt !== 32'd1) begin errors++; $display("FAIL fl_cnt: got %0d want 1", fetch_cnt); end
    // Halt in FLUSH wins: hold pc, still squash.
    br_taken = 1; br_target = 64'h400; tick();
    br_taken = 0; halt = 1; pc = 64'h400;
    #1;
    checks++; if (next_pc !== 64'h400) begin errors++; $display("FAIL flh_npc: got %h want 400", next_pc); end
    checks++; if (flush !== 1'b1) begin errors++; $display("FAIL flh_flush: got %b want 1", flush); end
    tick();
    checks++; if (state !== 2'b11) begin errors++; $display("FAIL flh_state: got %b want 11", state); end
  endtask

  task automatic test_misalign();
    do_reset();
    pc = 64'h40; stall = 1; br_taken = 1; br_target = 64'h202;
    #1;
    checks++; if (next_pc !== 64'h200) begin errors++; $display("FAIL mis_npc: got %h want 200", next_pc); end
    tick();
    checks++; if (state !== 2'b10) begin errors++; $display("FAIL mis_state: got %b want 10", state); end
    checks++; if (misalign !== 1'b1) begin errors++; $display("FAIL mis_set: got %b want 1", misalign); end
    idle_inputs(); pc = 64'h200;
    repeat (4) tick();
    checks++; if (misalign !== 1'b1) begin errors++; $display("FAIL mis_sticky: got %b want 1", misalign); end
    reset = 1; tick(); reset = 0;
    checks++; if (misalign !== 1'b0) begin errors++; $display("FAIL mis_clear: got %b want 0", misalign); end
    // Aligned-target redirect from STALL does not set it; misaligned one does.
    stall = 1; tick();
    br_taken = 1; br_target = 64'h800; tick();
    checks++; if (misalign !== 1'b0) begin errors++; $display("FAIL mis_aligned: got %b want 0", misalign); end
    br_taken = 0; tick(); stall = 1; tick();
    br_taken = 1; br_target = 64'h803; #1;
    checks++; if (next_pc !== 64'h800) begin errors++; $display("FAIL mis_st_npc: got %h want 800", next_pc); end
    tick();
    checks++; if (misalign !== 1'b1) begin errors++; $display("FAIL mis_st_set: got %b want 1", misalign); end
  endtask

  task automatic test_halt();
    do_reset();
    pc = 64'h80; halt = 1;
    #1;
    checks++; if (next_pc !== 64'h80) begin errors++; $display("FAIL halt_npc: got %h want 80", next_pc); end
    checks++; if (flush !== 1'b0) begin errors++; $display("FAIL halt_flush: got %b want 0", flush); end
    tick();
    halt = 0; br_taken = 1; br_target = 64'h300;
    for (int i = 0; i < 5; i++) begin
      stall = 1'($urandom_range(0, 1));
      pc = 64'h80 + 64'(i * 8);
      #1;
      checks++; if (next_pc !== pc || flush !== 1'b0) begin errors++; $display("FAIL halted_out%0d: got %h/%b want %h/0", i, next_pc, flush, pc); end
      tick();
      checks++; if (state !== 2'b11) begin errors++; $display("FAIL halted_state%0d: got %b want 11", i, state); end
    end
    checks++; if (fetch_cnt !== 32'd0 || misalign !== 1'b0) begin errors++; $display("FAIL halted_regs: got cnt %0d mis %b want 0/0", fetch_cnt, misalign); end
    reset = 1;
    #1;
    checks++; if (next_pc !== 64'h0 || flush !== 1'b1) begin errors++; $display("FAIL halt_rst_out: got %h/%b want 0/1", next_pc, flush); end
    tick();
    reset = 0; idle_inputs(); pc = 64'h0;
    checks++; if (state !== 2'b00) begin errors++; $display("FAIL halt_rst_state: got %b want 00", state); end
    #1;
    checks++; if (next_pc !== 64'h4) begin errors++; $display("FAIL halt_rst_npc: got %h want 4", next_pc); end
  endtask

  task automatic test_wrap_and_saturation();
    logic [31:0] want;
    do_reset();
    pc = 64'hFFFF_FFFF_FFFF_FFFC;
    #1;
    checks++; if (next_pc !== 64'h0) begin errors++; $display("FAIL wrap_npc: got %h want 0", next_pc); end
    tick();
    checks++; if (state !== 2'b00 || fetch_cnt !== 32'd1) begin errors++; $display("FAIL wrap_regs: got %b/%0d want 00/1", state, fetch_cnt); end
    force dut.r_fetch_cnt = 32'hFFFF_FFFC;
    #1;
    release dut.r_fetch_cnt;
    pc = 64'h0;
    want = 32'hFFFF_FFFC;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (want != 32'hFFFF_FFFF) want = want + 32'd1;
      checks++; if (fetch_cnt !== want) begin errors++; $display("FAIL sat_cnt%0d: got %h want %h", i, fetch_cnt, want); end
    end
  endtask

  // Behavioural reference: the sequencer is described by which mode it is in.
  bit          m_halted, m_flushing, m_stalled, m_mis;
  logic [31:0] m_cnt;

  task automatic test_random();
    logic [63:0] e_npc;
    logic        e_flush;
    logic [1:0]  e_state;
    logic [63:0] nxt_pc;
    do_reset();
    m_halted = 0; m_flushing = 0; m_stalled = 0; m_mis = 0; m_cnt = 0;
    nxt_pc = 64'h0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      reset     = ($urandom_range(0, 39) == 0);
      halt      = ($urandom_range(0, 49) == 0);
      br_taken  = ($urandom_range(0, 5) == 0);
      stall     = ($urandom_range(0, 3) == 0);
      br_target = {$urandom, $urandom};
      case ($urandom_range(0, 3))
        0:       pc = {$urandom, $urandom};
        1:       pc = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 15));
        default: pc = nxt_pc;
      endcase
      if (reset) begin
        e_npc = 64'h0; e_flush = 1;
      end else if (m_halted) begin
        e_npc = pc; e_flush = 0;
      end else if (m_flushing) begin
        e_flush = 1; e_npc = halt ? pc : pc + 64'd4;
      end else if (halt) begin
        e_npc = pc; e_flush = 0;
      end else if (br_taken) begin
        e_npc = br_target & ~64'h3; e_flush = 1;
      end else begin
        e_npc = stall ? pc : pc + 64'd4; e_flush = 0;
      end
      #1;
      checks++; if (next_pc !== e_npc || flush !== e_flush) begin errors++; $display("FAIL rnd_comb c%0d: got %h/%b want %h/%b", cyc, next_pc, flush, e_npc, e_flush); end
      nxt_pc = e_npc;
      if (reset) begin
        m_halted = 0; m_flushing = 0; m_stalled = 0; m_mis = 0; m_cnt = 0;
      end else if (m_halted) begin
      end else if (halt) begin
        m_halted = 1; m_flushing = 0; m_stalled = 0;
      end else if (m_flushing) begin
        m_flushing = 0;
        if (m_cnt != 32'hFFFF_FFFF) m_cnt++;
      end else if (br_taken) begin
        m_flushing = 1; m_stalled = 0;
        if (br_target[1:0] != 2'b00) m_mis = 1;
      end else if (stall) begin
        m_stalled = 1;
      end else begin
        m_stalled = 0;
        if (m_cnt != 32'hFFFF_FFFF) m_cnt++;
      end
      e_state = m_halted ? 2'b11 : m_flushing ? 2'b10 : m_stalled ? 2'b01 : 2'b00;
      tick();
      checks++; if (state !== e_state || misalign !== m_mis || fetch_cnt !== m_cnt) begin
        errors++;
        $display("FAIL rnd_regs c%0d: got st %b mis %b cnt %0d want st %b mis %b cnt %0d", cyc, state, misalign, fetch_cnt, e_state, m_mis, m_cnt);
      end
    end
    reset = 0; idle_inputs();
  endtask

  initial begin
    reset = 1; pc = 64'h0; idle_inputs();
    test_reset();
    test_sequential();
    test_stall();
    test_branch();
    test_misalign();
    test_halt();
    test_wrap_and_saturation();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on rising edge.
REQ-002 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have port pc, input, 64 bits: current PC, taken from the PC register output.
REQ-004 SHALL have port next_pc, output, 64 bits: value driven into the PC register input.
REQ-005 SHALL have port stall, input, 1 bit: hazard-unit request to hold fetch.
REQ-006 SHALL have port br_taken, input, 1 bit: resolved taken branch (B, CBZ or BR) this cycle.
REQ-007 SHALL have port br_target, input, 64 bits: branch destination address.
REQ-008 SHALL have port halt, input, 1 bit: stop fetching permanently until reset.
REQ-009 SHALL have port flush, output, 1 bit: squash IF/ID contents.
REQ-010 SHALL have port state, output, 2 bits: FSM state encoding.
REQ-011 SHALL have port misalign, output, 1 bit: sticky flag for a misaligned branch target.
REQ-012 SHALL have port fetch_cnt, output, 32 bits: count of sequential advances.

Function
REQ-013 SHALL implement FSM states RUN=2'b00, STALL=2'b01, FLUSH=2'b10, HALTED=2'b11; state output is the registered state.
REQ-014 next_pc and flush SHALL be combinational (Mealy) from the registered state and the current inputs; state, misalign and fetch_cnt SHALL be registered.
REQ-015 pc+4 SHALL be computed modulo 2^64: pc=64'hFFFF_FFFF_FFFF_FFFC yields 0, with no error.
REQ-016 Input priority in RUN and STALL SHALL be halt > br_taken > stall > sequential.
REQ-017 RUN with halt=1: next_pc=pc, flush=0, next state HALTED.
REQ-018 RUN with br_taken=1: next_pc={br_target[63:2],2'b00}, flush=1, next state FLUSH.
REQ-019 RUN with stall=1 (no branch): next_pc=pc, flush=0, next state STALL.
REQ-020 RUN otherwise: next_pc=pc+4, flush=0, stay RUN, fetch_cnt increments.
REQ-021 STALL: same priority rules; when stall=0 and no branch/halt, next_pc=pc+4, fetch_cnt increments, next state RUN; while stall stays 1, next_pc=pc and state remains STALL.
REQ-022 FLUSH lasts exactly one cycle: flush=1, next_pc=pc+4, fetch_cnt increments, stall ignored, next state RUN.
REQ-023 In FLUSH, halt=1 SHALL take priority: next_pc=pc, flush=1, next state HALTED.
REQ-024 In FLUSH, br_taken SHALL be ignored, because it comes from a squashed instruction.
REQ-025 HALTED: next_pc=pc, flush=0, all inputs ignored; the block leaves HALTED only on reset.
REQ-026 Whenever a redirect is taken (REQ-018 or REQ-021 branch) and br_target[1:0]!=0, misalign SHALL set on the next edge and stay set until reset; the redirect still uses the target with bits [1:0] forced to 00.
REQ-027 fetch_cnt SHALL saturate at 32'hFFFF_FFFF and never wrap.

Reset
REQ-028 With reset=1 at a rising edge: state=RUN, misalign=0, fetch_cnt=0.
REQ-029 While reset=1, next_pc SHALL be 64'h0 and flush SHALL be 1, whatever the state or inputs.
REQ-030 Reset asserted mid-stall, mid-flush or in HALTED SHALL take effect on that edge with no residual state; the first cycle after reset behaves as RUN.

Verification
REQ-031 Reset, then 3 idle cycles with pc fed back from next_pc -> next_pc sequence 4, 8, 12; fetch_cnt=3; state=RUN.
REQ-032 pc=0x10, stall held 2 cycles -> next_pc=0x10 for both cycles with state=STALL; on release next_pc=0x14, state=RUN.
REQ-033 pc=0x20, br_taken=1, br_target=0x100 -> next_pc=0x100, flush=1; next cycle state=FLUSH, flush=1, next_pc=0x104; then state=RUN, flush=0.
REQ-034 stall=1 and br_taken=1 together with br_target=0x202 -> next_pc=0x200, state goes to FLUSH, misalign=1 thereafter until reset.
REQ-035 halt=1 in RUN -> state=HALTED and next_pc=pc indefinitely; a later br_taken has no effect; reset returns to RUN with next_pc=0.
REQ-036 pc=64'hFFFF_FFFF_FFFF_FFFC in RUN -> next_pc=0; fetch_cnt preset near max via a long run saturates at 32'hFFFF_FFFF.
